i2c_target_regs: RTL and testbench

I2C target (slave) responder with an internal byte-wide register bank, addressed like a DS3231M (7-bit address 0x68, register-pointer protocol). It is the bus-side counterpart of the i2c master controller. It is used to emulate the RTC in simulation and on-board loopback, and later as a generic register target. Local logic such as a timekeeping counter updates registers through a side write port.

---
 rtl/i2c_target_regs.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank and register-pointer protocol (DS3231M style).
// Optional SCL-low bus timeout is compiled in when I2C_TGT_TIMEOUT_EN is defined.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter int         NUM_REGS    = 19,
    parameter int         PTR_W       = 5,
    parameter int         FILT_LEN    = 3,
    parameter int         TIMEOUT_CYC = 1_750_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_scl,
    input  logic             i_sda,
    output logic             o_sda_low,
    input  logic             i_loc_we,
    input  logic [PTR_W-1:0] i_loc_addr,
    input  logic [7:0]       i_loc_data,
    output logic             o_bus_wr,
    output logic [PTR_W-1:0] o_bus_wr_addr,
    output logic [7:0]       o_bus_wr_data,
    output logic             o_busy
);
    localparam int               FC_W       = $clog2(FILT_LEN + 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REGS - 1);
    localparam logic [7:0]       NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
    } state_t;

    // Line 0 is SCL, line 1 is SDA; both idle high.
    logic [1:0] pin_in;
    logic [1:0] filt_lvl;
    logic [1:0] prev_reg;
    assign pin_in = {i_sda, i_scl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic            sync1_reg, sync2_reg, filt_reg;
            logic [FC_W-1:0] cnt_reg;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= pin_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FC_W'(FILT_LEN - 1)) begin
                        filt_reg <= sync2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + FC_W'(1);
                    end
                end
            end
            assign filt_lvl[gi] = filt_reg;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) prev_reg <= 2'b11;
        else       prev_reg <= filt_lvl;
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    assign scl_f     = filt_lvl[0];
    assign sda_f     = filt_lvl[1];
    assign scl_rise  = scl_f & ~prev_reg[0];
    assign scl_fall  = ~scl_f & prev_reg[0];
    assign start_det = scl_f & prev_reg[0] & prev_reg[1] & ~sda_f;
    assign stop_det  = scl_f & prev_reg[0] & ~prev_reg[1] & sda_f;

    // Register bank: a bus write lands on the cycle o_bus_wr is high and wins over a local write.
    logic [7:0] regs [NUM_REGS];
    logic [7:0] rd_data_reg;
    logic [PTR_W-1:0] ptr_reg;

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] r_reg;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_reg <= 8'h00;
                end else if (o_bus_wr && o_bus_wr_addr == PTR_W'(gi)) begin
                    r_reg <= o_bus_wr_data;
                end else if (i_loc_we && i_loc_addr == PTR_W'(gi)) begin
                    r_reg <= i_loc_data;
                end
            end
            assign regs[gi] = r_reg;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) rd_data_reg <= 8'h00;
        else       rd_data_reg <= regs[ptr_reg];
    end

    state_t           state_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             phase_reg;
    logic             rw_reg;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc;
    logic             to_hit;

    assign rx_byte = {shift_reg[6:0], sda_f};
    assign ptr_inc = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + PTR_ONE;

    logic unused_msb;
    assign unused_msb = shift_reg[7];

`ifdef I2C_TGT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_reg;
    always_ff @(posedge i_clk) begin
        if (i_rst || state_reg == IDLE || scl_f) begin
            to_cnt_reg <= '0;
        end else if (to_cnt_reg != TO_W'(TIMEOUT_CYC)) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end
    assign to_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            phase_reg     <= 1'b0;
            rw_reg        <= 1'b0;
            ptr_reg       <= '0;
            o_sda_low     <= 1'b0;
            o_bus_wr      <= 1'b0;
            o_bus_wr_addr <= '0;
            o_bus_wr_data <= 8'h00;
            o_busy        <= 1'b0;
        end else begin
            o_bus_wr <= 1'b0;
            if (start_det) begin
                state_reg   <= ADDR;
                bit_cnt_reg <= 3'd0;
                phase_reg   <= 1'b0;
                o_sda_low   <= 1'b0;
            end else if (stop_det || to_hit) begin
                state_reg <= IDLE;
                o_sda_low <= 1'b0;
                o_busy    <= 1'b0;
            end else begin
                case (state_reg)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift_reg   <= rx_byte;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            phase_reg   <= 1'b0;
                            if (bit_cnt_reg == 3'd7) begin
                                if (state_reg == ADDR) begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_reg <= ADDR_ACK;
                                        rw_reg    <= rx_byte[0];
                                        o_busy    <= 1'b1;
                                    end else begin
                                        state_reg <= IDLE;
                                        o_busy    <= 1'b0;
                                    end
                                end else if (state_reg == PTR) begin
                                    ptr_reg   <= (rx_byte < NUM_REGS_B) ? rx_byte[PTR_W-1:0] : '0;
                                    state_reg <= PTR_ACK;
                                end else begin
                                    o_bus_wr      <= 1'b1;
                                    o_bus_wr_addr <= ptr_reg;
                                    o_bus_wr_data <= rx_byte;
                                    ptr_reg       <= ptr_inc;
                                    state_reg     <= WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK pulse, second one ends it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!phase_reg) begin
                                o_sda_low <= 1'b1;
                                phase_reg <= 1'b1;
                            end else begin
                                phase_reg   <= 1'b0;
                                bit_cnt_reg <= 3'd0;
                                if (state_reg == ADDR_ACK && rw_reg) begin
                                    shift_reg <= rd_data_reg;
                                    o_sda_low <= ~rd_data_reg[7];
                                    state_reg <= RDATA;
                                end else begin
                                    o_sda_low <= 1'b0;
                                    state_reg <= (state_reg == ADDR_ACK) ? PTR : WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                o_sda_low <= 1'b0;
                                ptr_reg   <= ptr_inc;
                                phase_reg <= 1'b0;
                                state_reg <= MACK;
                            end else begin
                                o_sda_low   <= ~shift_reg[6];
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            if (sda_f) state_reg <= WAIT_STOP;
                            else       phase_reg <= 1'b1;
                        end else if (scl_fall && phase_reg) begin
                            phase_reg   <= 1'b0;
                            bit_cnt_reg <= 3'd0;
                            shift_reg   <= rd_data_reg;
                            o_sda_low   <= ~rd_data_reg[7];
                            state_reg   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, vector table, directed corners, random transactions.
module tb_i2c_target_regs;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       o_sda_low, o_bus_wr, o_busy;
    logic       i_loc_we;
    logic [4:0] i_loc_addr, o_bus_wr_addr;
    logic [7:0] i_loc_data, o_bus_wr_data;

    always #5 clk = ~clk;
    assign sda_line = sda_m & ~o_sda_low;

    i2c_target_regs #(.TIMEOUT_CYC(1000)) dut (
        .i_clk(clk), .i_rst(rst), .i_scl(scl_m), .i_sda(sda_line), .o_sda_low(o_sda_low),
        .i_loc_we(i_loc_we), .i_loc_addr(i_loc_addr), .i_loc_data(i_loc_data),
        .o_bus_wr(o_bus_wr), .o_bus_wr_addr(o_bus_wr_addr), .o_bus_wr_data(o_bus_wr_data),
        .o_busy(o_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed bus writes and the reference model
    logic [12:0] wr_q[$];
    logic [12:0] exp_q[$];
    logic [7:0]  m_regs[19];
    int          m_ptr;
    logic [7:0]  wbuf[8];
    logic [7:0]  rbuf[8];
    logic        got_aack, got_acks, got_busy, got_rel, last_busy;

    always @(negedge clk) if (o_bus_wr === 1'b1) wr_q.push_back({o_bus_wr_addr, o_bus_wr_data});

    task automatic hq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b, output logic s);
        sda_m = b; hq(Q);
        scl_m = 1'b1; hq(Q);
        s = sda_line; last_busy = o_busy; hq(Q);
        scl_m = 1'b0; hq(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1; hq(Q); scl_m = 1'b1; hq(Q); sda_m = 1'b0; hq(Q); scl_m = 1'b0; hq(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0; hq(Q); scl_m = 1'b1; hq(Q); sda_m = 1'b1; hq(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i], s);
        bit_out(1'b1, s);
        ack = ~s;
    endtask

    task automatic rbyte(input logic ack_m, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, s);
            b[i] = s;
        end
        bit_out(~ack_m, s);
    endtask

    task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        got_acks = 1'b1;
        start_c();
        wbyte({a, 1'b0}, ack);
        got_aack = ack;
        got_busy = last_busy;
        if (ack) begin
            wbyte(p, ack); got_acks &= ack;
            for (int k = 0; k < n; k++) begin
                wbyte(wbuf[k], ack); got_acks &= ack;
            end
        end
        stop_c();
    endtask

    task automatic xfer_read(input logic [6:0] a, input int n, input logic set_ptr, input logic [7:0] p);
        logic ack;
        if (set_ptr) begin
            start_c(); wbyte(8'hD0, ack); wbyte(p, ack);
        end
        start_c();
        wbyte({a, 1'b1}, ack);
        got_aack = ack;
        got_rel  = 1'b1;
        if (ack) begin
            for (int k = 0; k < n; k++) rbyte(k != n - 1, rbuf[k]);
            got_rel = ~o_sda_low;
        end
        stop_c();
    endtask

    // Model: pointer/register semantics at transaction level.
    task automatic m_write(input logic [6:0] a, input logic [7:0] p, input int n);
        if (a != 7'h68) return;
        m_ptr = (p < 19) ? int'(p) : 0;
        for (int k = 0; k < n; k++) begin
            m_regs[m_ptr] = wbuf[k];
            exp_q.push_back({5'(m_ptr), wbuf[k]});
            m_ptr = (m_ptr + 1) % 19;
        end
    endtask

    task automatic m_read_check(input string name, input int n, input logic set_ptr, input logic [7:0] p);
        if (set_ptr) m_ptr = (p < 19) ? int'(p) : 0;
        for (int k = 0; k < n; k++) begin
            check(name, rbuf[k], m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % 19;
        end
    endtask

    task automatic compare_wr(input string name);
        check({name, "_cnt"}, wr_q.size(), exp_q.size());
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) check(name, wr_q[k], exp_q[k]);
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        i_loc_we = 1'b1; i_loc_addr = a; i_loc_data = d;
        @(negedge clk);
        i_loc_we = 1'b0;
        m_regs[a] = d;
    endtask

    // Drives a local write into the exact cycle a bus write lands.
    task automatic collide(input logic [4:0] a, input logic [7:0] d);
        int t = 0;
        do begin @(negedge clk); t++; end while (o_bus_wr !== 1'b1 && t < 3000);
        check("collide_seen", o_bus_wr, 1'b1);
        if (o_bus_wr === 1'b1) begin
            i_loc_we = 1'b1; i_loc_addr = a; i_loc_data = d;
            @(negedge clk);
            i_loc_we = 1'b0;
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        logic [4:0] exp_addr;
    } vec_t;
    vec_t vt[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic s, ack, exp_hold;
        vt[0] = '{7'h68, 8'h00, 8'h45, 1'b1, 5'd0};
        vt[1] = '{7'h50, 8'h03, 8'h12, 1'b0, 5'd0};
        vt[2] = '{7'h68, 8'h1F, 8'h5A, 1'b1, 5'd0};
        vt[3] = '{7'h69, 8'h00, 8'h77, 1'b0, 5'd0};
        vt[4] = '{7'h68, 8'h12, 8'hAA, 1'b1, 5'd18};
        vt[5] = '{7'h68, 8'h13, 8'hC3, 1'b1, 5'd0};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        i_loc_we = 1'b0; i_loc_addr = '0; i_loc_data = '0;
        for (int k = 0; k < 19; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        hq(4);
        check("rst_sda_low", o_sda_low, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_bus_wr", o_bus_wr, 1'b0);
        check("rst_wr_addr", o_bus_wr_addr, 5'd0);
        check("rst_wr_data", o_bus_wr_data, 8'd0);
        rst = 1'b0;
        hq(20);

        for (int i = 0; i < 6; i++) begin
            wbuf[0] = vt[i].data;
            xfer_write(vt[i].addr, vt[i].ptr, 1);
            m_write(vt[i].addr, vt[i].ptr, 1);
            $display("vec %0d addr=%0h ptr=%0h data=%0h ack=%0b", i, vt[i].addr, vt[i].ptr, vt[i].data, got_aack);
            check("vec_addr_ack", got_aack, vt[i].exp_ack);
            check("vec_busy_at_ack", got_busy, vt[i].exp_ack);
            check("vec_busy_after", o_busy, 1'b0);
            check("vec_wr_cnt", wr_q.size(), vt[i].exp_ack ? 1 : 0);
            if (vt[i].exp_ack) begin
                check("vec_data_acks", got_acks, 1'b1);
                if (wr_q.size() > 0) check("vec_wr", wr_q[0], {vt[i].exp_addr, vt[i].data});
            end
            wr_q.delete();
            exp_q.delete();
        end
        xfer_read(7'h68, 1, 1'b1, 8'h00);
        $display("read reg0 got=%0h", rbuf[0]);
        m_read_check("reg0_read", 1, 1'b1, 8'h00);

        // Repeated-START read of 3 bytes with ACK, ACK, NACK
        loc_write(5, 8'h11); loc_write(6, 8'h22); loc_write(7, 8'h33); loc_write(8, 8'h8E);
        xfer_read(7'h68, 3, 1'b1, 8'h05);
        $display("sr_read got=%0h %0h %0h", rbuf[0], rbuf[1], rbuf[2]);
        check("sr_aack", got_aack, 1'b1);
        check("sr_b0", rbuf[0], 8'h11);
        check("sr_b1", rbuf[1], 8'h22);
        check("sr_b2", rbuf[2], 8'h33);
        check("sr_release", got_rel, 1'b1);
        xfer_read(7'h68, 1, 1'b0, 8'h00);
        check("ptr_after_read", rbuf[0], 8'h8E);
        m_ptr = 9;

        // Wrap across the last register
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        xfer_write(7'h68, 8'h12, 2);
        m_write(7'h68, 8'h12, 2);
        $display("wrap write wr_events=%0d", wr_q.size());
        check("wrap_cnt", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("wrap_w0", wr_q[0], {5'd18, 8'hAA});
            check("wrap_w1", wr_q[1], {5'd0, 8'hBB});
        end
        wr_q.delete(); exp_q.delete();
        xfer_read(7'h68, 2, 1'b1, 8'h12);
        check("wrap_r18", rbuf[0], 8'hAA);
        check("wrap_r0", rbuf[1], 8'hBB);
        m_ptr = 1;

        // Same-address collision: bus wins
        wbuf[0] = 8'h99;
        fork
            xfer_write(7'h68, 8'h03, 1);
            collide(5'd3, 8'h77);
        join
        m_write(7'h68, 8'h03, 1);
        compare_wr("collide_wr");
        xfer_read(7'h68, 1, 1'b1, 8'h03);
        $display("collide same got=%0h", rbuf[0]);
        check("collide_same", rbuf[0], 8'h99);
        m_ptr = 4;

        // Different-address collision: both land
        wbuf[0] = 8'h66;
        fork
            xfer_write(7'h68, 8'h03, 1);
            collide(5'd4, 8'h5C);
        join
        m_regs[4] = 8'h5C;
        m_write(7'h68, 8'h03, 1);
        compare_wr("collide2_wr");
        xfer_read(7'h68, 2, 1'b1, 8'h03);
        $display("collide diff got=%0h %0h", rbuf[0], rbuf[1]);
        check("collide_diff3", rbuf[0], 8'h66);
        check("collide_diff4", rbuf[1], 8'h5C);
        m_ptr = 5;

        // STOP in the middle of a data byte discards it
        start_c(); wbyte(8'hD0, ack); wbyte(8'h02, ack);
        for (int i = 0; i < 4; i++) bit_out(1'b1, s);
        stop_c();
        m_ptr = 2;
        $display("abort wr_events=%0d busy=%0b", wr_q.size(), o_busy);
        check("abort_no_wr", wr_q.size(), 0);
        check("abort_busy", o_busy, 1'b0);
        wr_q.delete();
        xfer_read(7'h68, 1, 1'b1, 8'h02);
        m_read_check("abort_reg2", 1, 1'b1, 8'h02);

        // Randomized transactions against the model
        for (int it = 0; it < 22; it++) begin
            int kind, n;
            logic [7:0] p;
            logic [6:0] a;
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 4);
            p    = 8'($urandom_range(0, 31));
            case (kind)
                0: begin
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    xfer_write(7'h68, p, n);
                    m_write(7'h68, p, n);
                    $display("rand %0d write ptr=%0h n=%0d", it, p, n);
                    check("rand_w_acks", {got_aack, got_acks}, 2'b11);
                    compare_wr("rand_w");
                end
                1: begin
                    logic sp;
                    sp = 1'($urandom);
                    if (n > 3) n = 3;
                    xfer_read(7'h68, n, sp, p);
                    $display("rand %0d read setptr=%0b ptr=%0h n=%0d b0=%0h", it, sp, p, n, rbuf[0]);
                    check("rand_r_ack", got_aack, 1'b1);
                    m_read_check("rand_r", n, sp, p);
                end
                2: begin
                    logic [4:0] la;
                    logic [7:0] ld;
                    la = 5'($urandom_range(0, 18));
                    ld = 8'($urandom);
                    loc_write(la, ld);
                    $display("rand %0d local addr=%0d data=%0h", it, la, ld);
                end
                default: begin
                    do a = 7'($urandom); while (a == 7'h68);
                    wbuf[0] = 8'($urandom);
                    xfer_write(a, p, 1);
                    $display("rand %0d foreign addr=%0h ack=%0b", it, a, got_aack);
                    check("rand_foreign_ack", got_aack, 1'b0);
                    check("rand_foreign_busy", got_busy, 1'b0);
                    compare_wr("rand_foreign");
                end
            endcase
        end

        // Stuck SCL while driving a 0 data bit, then reset mid-transfer
        loc_write(5'd10, 8'h3C);
        start_c(); wbyte(8'hD0, ack); wbyte(8'h0A, ack);
        start_c(); wbyte(8'hD1, ack);
        check("stuck_pre_drive", o_sda_low, 1'b1);
        check("stuck_pre_busy", o_busy, 1'b1);
        hq(1100);
`ifdef I2C_TGT_TIMEOUT_EN
        exp_hold = 1'b0;
`else
        exp_hold = 1'b1;
`endif
        $display("stuck scl sda_low=%0b busy=%0b", o_sda_low, o_busy);
        check("stuck_sda_low", o_sda_low, exp_hold);
        check("stuck_busy", o_busy, exp_hold);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("midrst_sda_low", o_sda_low, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        for (int k = 0; k < 19; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        scl_m = 1'b1; sda_m = 1'b1; hq(4 * Q);
        xfer_read(7'h68, 2, 1'b0, 8'h00);
        $display("post reset read got=%0h %0h", rbuf[0], rbuf[1]);
        check("post_rst_ack", got_aack, 1'b1);
        m_read_check("post_rst_regs", 2, 1'b0, 8'h00);
        xfer_read(7'h68, 1, 1'b1, 8'h0A);
        m_read_check("post_rst_reg10", 1, 1'b1, 8'h0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
